temp_alarm_fsm: RTL

Parametrised temperature supervision state machine, successor to the fixed three-flag alarm FSM (`M_Estados`). It consumes a binary temperature sample instead of discrete threshold flags, and applies programmable thresholds, debounce and hysteresis. It adds a latched alarm with operator acknowledge and a non-recoverable cutoff trip on `t_corp`. It sits between the sensor front-end and the notification/abandon/alarm drivers.

---
 rtl/temp_alarm_fsm.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/temp_alarm_fsm.sv
// ---------------------------------------------------------------------------
// temp_alarm_fsm
//   Temperature supervision state machine. A binary temperature sample is
//   classified against three programmable thresholds. Escalation and
//   de-escalation both need DEBOUNCE consecutive qualifying valid samples.
//   De-escalation additionally needs the sample to sit HYST below the
//   current level's threshold. Leaving ALARM needs an operator acknowledge.
//   An external cutoff (t_corp) forces an absorbing TRIP state.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   temp       in   unsigned temperature sample [TEMP_W-1:0]
//   temp_valid in   temp is sampled only when high
//   t_corp     in   cutoff request, level-sensitive, forces TRIP
//   ack        in   operator acknowledge (only meaningful in ALARM)
//   notif      out  NOTIF | ABAN | ALARM
//   aban       out  ABAN | ALARM | TRIP
//   alarm      out  ALARM | TRIP
//   level      out  state code: NORMAL=0 NOTIF=1 ABAN=2 ALARM=3 TRIP=4
// ---------------------------------------------------------------------------
module temp_alarm_fsm #(
  parameter int unsigned TEMP_W   = 8,
  parameter int unsigned TH_NOTIF = 25,
  parameter int unsigned TH_ABAN  = 27,
  parameter int unsigned TH_ALARM = 30,
  parameter int unsigned HYST     = 1,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TEMP_W-1:0] temp,
  input  logic              temp_valid,
  input  logic              t_corp,
  input  logic              ack,
  output logic              notif,
  output logic              aban,
  output logic              alarm,
  output logic [2:0]        level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

  localparam logic [CNT_W-1:0]  DEB_C   = CNT_W'(DEBOUNCE);
  localparam logic [TEMP_W-1:0] TH_N_C  = TEMP_W'(TH_NOTIF);
  localparam logic [TEMP_W-1:0] TH_B_C  = TEMP_W'(TH_ABAN);
  localparam logic [TEMP_W-1:0] TH_A_C  = TEMP_W'(TH_ALARM);
  localparam logic [TEMP_W-1:0] HYST_C  = TEMP_W'(HYST);

  // State codes double as level numbers so tgt and state compare directly.
  typedef enum logic [2:0] {
    S_NORMAL = 3'd0,
    S_NOTIF  = 3'd1,
    S_ABAN   = 3'd2,
    S_ALARM  = 3'd3,
    S_TRIP   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  up_cnt_q, up_cnt_d;
  logic [CNT_W-1:0]  dn_cnt_q, dn_cnt_d;
  logic              ack_pend_q, ack_pend_d;

  logic [2:0]        tgt;
  logic [2:0]        lvl_down;
  logic [TEMP_W-1:0] th_dn;
  logic              up_qual;
  logic              dn_qual;
  logic              dn_allowed;

  // Level the current sample asks for.
  always_comb begin
    if (temp >= TH_A_C)      tgt = 3'd3;
    else if (temp >= TH_B_C) tgt = 3'd2;
    else if (temp >= TH_N_C) tgt = 3'd1;
    else                     tgt = 3'd0;
  end

  // De-escalation threshold of the current level. A zero threshold makes
  // dn_qual impossible, which covers NORMAL and TRIP.
  always_comb begin
    unique case (state_q)
      S_NOTIF: th_dn = TH_N_C - HYST_C;
      S_ABAN:  th_dn = TH_B_C - HYST_C;
      S_ALARM: th_dn = TH_A_C - HYST_C;
      default: th_dn = '0;
    endcase
  end

  assign up_qual  = (state_q != S_TRIP) && (tgt > state_q);
  assign dn_qual  = (temp < th_dn);
  assign lvl_down = state_q - 3'd1;
  // Leaving ALARM downward needs an acknowledge seen now or earlier.
  assign dn_allowed = (state_q != S_ALARM) || ack_pend_q || ack;

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_d    = state_q;
    up_cnt_d   = up_cnt_q;
    dn_cnt_d   = dn_cnt_q;
    ack_pend_d = ack_pend_q;

    // Counters move only on valid samples; invalid cycles hold them.
    if (temp_valid) begin
      if (up_qual) begin
        up_cnt_d = (up_cnt_q == DEB_C) ? DEB_C : up_cnt_q + 1'b1;
        dn_cnt_d = '0;
      end else if (dn_qual) begin
        dn_cnt_d = (dn_cnt_q == DEB_C) ? DEB_C : dn_cnt_q + 1'b1;
        up_cnt_d = '0;
      end else begin
        up_cnt_d = '0;
        dn_cnt_d = '0;
      end
    end

    if ((state_q == S_ALARM) && ack) ack_pend_d = 1'b1;

    // A saturated down count in ALARM waits here until ack arrives, so the
    // step can happen on a cycle with temp_valid low.
    if (up_cnt_d == DEB_C) begin
      state_d = state_e'(tgt);
    end else if ((dn_cnt_d == DEB_C) && dn_allowed) begin
      state_d = state_e'(lvl_down);
    end

    if (t_corp || (state_q == S_TRIP)) state_d = S_TRIP;

    if (state_d != state_q) begin
      up_cnt_d   = '0;
      dn_cnt_d   = '0;
      ack_pend_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_NORMAL;
      up_cnt_q   <= '0;
      dn_cnt_q   <= '0;
      ack_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      up_cnt_q   <= up_cnt_d;
      dn_cnt_q   <= dn_cnt_d;
      ack_pend_q <= ack_pend_d;
    end
  end

  // Moore decode straight off the state register.
  assign notif = (state_q == S_NOTIF) || (state_q == S_ABAN) || (state_q == S_ALARM);
  assign aban  = (state_q == S_ABAN)  || (state_q == S_ALARM) || (state_q == S_TRIP);
  assign alarm = (state_q == S_ALARM) || (state_q == S_TRIP);
  assign level = state_q;

endmodule
